alu_op_sequencer: RTL

Sequences the shared combinational ALU (A, B, opcode in; Zhigh, Zlow out) for multi-cycle use by the datapath control unit. It accepts one operation request per valid/ready handshake and drives registered operands and opcode into the ALU. It waits an opcode-dependent settle time, then captures Zhigh/Zlow into result registers and presents them on a valid/ready response port. Illegal opcodes and divide-by-zero are flagged without waiting on the ALU.

---
 rtl/alu_op_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a shared combinational ALU as a multi-cycle unit.
// One request is accepted per handshake. Operands and opcode are registered
// toward the ALU. After an opcode-dependent settle time the ALU result is
// captured and offered on a response handshake. Illegal opcodes and divide
// by zero skip the ALU and respond at once with an error flag.
module alu_op_sequencer #(
  parameter int FAST_CYCLES   = 1,  // settle cycles for single-cycle ops, >= 1
  parameter int MULDIV_CYCLES = 4,  // settle cycles for MUL and DIV, >= 1
  parameter int CNT_W         = 3   // settle counter width
) (
  input  logic        clock,
  input  logic        clear,

  // request port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,

  // ALU interface
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_zhigh,
  input  logic [31:0] alu_zlow,

  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_zhigh,
  output logic [31:0] rsp_zlow,
  output logic        rsp_err,

  output logic        busy
);

  // Opcode map boundaries and the two slow operations.
  localparam logic [4:0] OP_FIRST = 5'b00011;  // ADD
  localparam logic [4:0] OP_LAST  = 5'b10010;  // NOT
  localparam logic [4:0] OP_MUL   = 5'b01111;
  localparam logic [4:0] OP_DIV   = 5'b10000;

  // The counter is loaded with L-1 so it reaches zero on the last settle edge.
  localparam logic [CNT_W-1:0] FAST_LOAD   = CNT_W'(FAST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] settle_cnt;

  logic             accept;
  logic             op_legal;
  logic             op_slow;
  logic             div_by_zero;
  logic             req_err;
  logic             settle_done;
  logic             rsp_done;
  logic [CNT_W-1:0] settle_load;

  // Request decode: legality, divide-by-zero and settle length.
  always_comb begin
    op_legal    = (req_opcode >= OP_FIRST) && (req_opcode <= OP_LAST);
    op_slow     = (req_opcode == OP_MUL) || (req_opcode == OP_DIV);
    div_by_zero = (req_opcode == OP_DIV) && (req_b == 32'd0);
    req_err     = !op_legal || div_by_zero;
    settle_load = op_slow ? MULDIV_LOAD : FAST_LOAD;
  end

  assign accept      = req_valid && (state == S_IDLE);
  assign settle_done = (state == S_EXEC) && (settle_cnt == '0);
  assign rsp_done    = (state == S_RESP) && rsp_ready;

  // Handshake and status outputs decode straight from the state.
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment ahead of the case keeps every path driven,
  // so no latch is inferred for state_next.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = req_err ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (settle_done) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_done) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // ALU operand and opcode registers; loaded only on accept, so they stay
  // stable through EXEC and RESP regardless of what the requester drives.
  // NOTE: these datapath registers are reset deliberately: their reset value
  // is visible on the ALU port and an abort must leave them at zero.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
    end else if (accept) begin
      alu_a      <= req_a;
      alu_b      <= req_b;
      alu_opcode <= req_opcode;
    end
  end

  // Settle counter: loaded on a legal accept, counts down during EXEC.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      settle_cnt <= '0;
    end else if (accept && !req_err) begin
      settle_cnt <= settle_load;
    end else if ((state == S_EXEC) && !settle_done) begin
      settle_cnt <= settle_cnt - 1'b1;
    end
  end

  // Result registers: zeros plus error on a rejected request, the ALU result
  // unmodified once it has settled; held for the whole of RESP.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      rsp_zhigh <= '0;
      rsp_zlow  <= '0;
      rsp_err   <= 1'b0;
    end else if (accept && req_err) begin
      rsp_zhigh <= '0;
      rsp_zlow  <= '0;
      rsp_err   <= 1'b1;
    end else if (settle_done) begin
      rsp_zhigh <= alu_zhigh;
      rsp_zlow  <= alu_zlow;
      rsp_err   <= 1'b0;
    end
  end

endmodule
